// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, data width and idle line level.
// Defining UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO for uart_tx: wrap-around pointers with one extra bit to tell FULL from EMPTY.
// Pushes are gated by the registered FULL only; a same-edge pop never makes room.
module uart_tx_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q + PtrW'(push_ok);
    rptr_d = rptr_q + PtrW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered 8N1 UART transmitter; back-to-back frames leave no idle gap.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  output logic       FULL,
  output logic       EMPTY,
  output logic       OVERRUN,
  output logic       BUSY,
  output logic       TXD
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   txd_q, txd_d;
  logic                   ovr_q, ovr_d;
  logic                   pop;
  logic                   bit_end;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (DATA_BITS)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .push_i  (WR_EN),
    .wdata_i (WR_DATA),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (FULL),
    .empty_o (EMPTY)
  );

  assign bit_end = (cnt_q == CntW'(BAUD_DIV - 1));
  assign ovr_d   = WR_EN & FULL;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        txd_d = IDLE_LEVEL;
        if (!EMPTY) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          txd_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          txd_d   = data_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            txd_d   = ^data_q;
            state_d = StParity;
`else
            txd_d   = IDLE_LEVEL;
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = data_q[idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          txd_d   = IDLE_LEVEL;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!EMPTY) begin
            pop     = 1'b1;
            data_d  = fifo_rdata;
            txd_d   = 1'b0;
            state_d = StStart;
          end else begin
            txd_d   = IDLE_LEVEL;
            state_d = StIdle;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        txd_d   = IDLE_LEVEL;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      txd_q   <= IDLE_LEVEL;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign TXD     = txd_q;
  assign BUSY    = (state_q != StIdle);
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected bytes, a line monitor decodes TXD frames.
module tb_uart_tx;

  localparam int Baud  = 4;
  localparam int Depth = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  localparam int Frame = NBits * Baud;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       WR_EN = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       FULL, EMPTY, OVERRUN, BUSY, TXD;

  uart_tx #(
    .BAUD_DIV   (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .OVERRUN (OVERRUN),
    .BUSY    (BUSY),
    .TXD     (TXD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  // Reference model: occupancy count plus the edge at which the transmitter may next pop.
  int m_count = 0;
  int m_n = 0;
  int m_free_at = 0;
  int ovr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle of input and checks the flags after the edge.
  task automatic tick(input logic wr, input logic [7:0] d);
    logic push, pop, ovr;
    WR_EN   = wr;
    WR_DATA = d;
    m_n++;
    ovr  = wr && (m_count == Depth);
    push = wr && (m_count < Depth);
    pop  = (m_count > 0) && (m_n >= m_free_at);
    if (pop) m_free_at = m_n + Frame;
    m_count = m_count + int'(push) - int'(pop);
    if (push) exp_q.push_back(d);
    @(negedge CLK);
    WR_EN = 1'b0;
    if (OVERRUN) ovr_seen++;
    chk("overrun", OVERRUN, ovr);
    chk("full", FULL, m_count == Depth);
    chk("empty", EMPTY, m_count == 0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_count != 0 || m_n <= m_free_at) && guard < 4000) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    chk("drain_timeout", guard < 4000, 1'b1);
    repeat (3) tick(1'b0, 8'h00);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_n       = 0;
    m_free_at = 0;
    exp_q.delete();
  endtask

  // Line monitor: decode each frame sample-by-sample and compare against the scoreboard.
  logic [NBits-1:0] mon_bits;
  logic             mon_abort, mon_stable;
  int               mon_b;
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RESET && TXD == 1'b0) begin
        starts.push_back(cyc);
        mon_abort  = 1'b0;
        mon_stable = 1'b1;
        mon_bits   = '0;
        for (int k = 0; k < Frame; k++) begin
          if (k != 0) @(negedge CLK);
          if (!RESET) begin
            mon_abort = 1'b1;
            break;
          end
          mon_b = k / Baud;
          if (k % Baud == 0) mon_bits[mon_b] = TXD;
          else if (TXD !== mon_bits[mon_b]) mon_stable = 1'b0;
        end
        if (!mon_abort) begin
          chk("bit_hold", mon_stable, 1'b1);
          chk("stop_bit", mon_bits[NBits-1], 1'b1);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", mon_bits[9], ^mon_bits[8:1]);
`endif
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'h0, mon_bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            chk("data_byte", mon_bits[8:1], exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ovr0;
    repeat (3) @(negedge CLK);
    chk("rst_txd", TXD, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_empty", EMPTY, 1'b1);
    chk("rst_full", FULL, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    #3 RESET = 1'b1;
    @(negedge CLK);
    model_reset();

    // Single frame: latency, length, then idle.
    tick(1'b1, 8'hA5);
    tick(1'b0, 8'h00);
    chk("latency_txd_low", TXD, 1'b0);
    repeat (Frame - 1) tick(1'b0, 8'h00);
    chk("frame_end_busy", BUSY, 1'b1);
    chk("frame_end_txd", TXD, 1'b1);
    tick(1'b0, 8'h00);
    chk("after_frame_busy", BUSY, 1'b0);
    drain();

    // Back-to-back frames with no idle gap.
    starts.delete();
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h02);
    drain();
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], Frame);

`ifdef UART_TX_PARITY_EN
    tick(1'b1, 8'h07);
    drain();
    tick(1'b1, 8'h03);
    drain();
`endif

    // Six consecutive writes: one dropped with a single OVERRUN pulse.
    ovr0 = ovr_seen;
    for (int i = 0; i < 6; i++) tick(1'b1, 8'h30 + 8'(i));
    drain();
    chk("overrun_pulses", ovr_seen - ovr0, 1);

    // Half-full FIFO, push on the same edge the transmitter pops.
    tick(1'b1, 8'h10);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h12);
    while (m_n + 1 < m_free_at) tick(1'b0, 8'h00);
    tick(1'b1, 8'h13);
    chk("pushpop_count", m_count, 2);
    drain();

    // Reset in the middle of data bit 3 with another byte queued.
    tick(1'b1, 8'hA5);
    tick(1'b1, 8'h3C);
    repeat (17) tick(1'b0, 8'h00);
    chk("pre_reset_txd", TXD, 1'b0);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst_txd", TXD, 1'b1);
    chk("async_rst_busy", BUSY, 1'b0);
    chk("async_rst_empty", EMPTY, 1'b1);
    chk("async_rst_full", FULL, 1'b0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    #3 RESET = 1'b1;
    @(negedge CLK);
    tick(1'b1, 8'h96);
    drain();

    // Random traffic with bursts that overflow the FIFO.
    for (int i = 0; i < 300; i++) begin
      if ((i / 40) % 2 == 1) tick(1'b1, 8'($urandom));
      else tick(($urandom_range(0, 99) < 30), 8'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
